// File: rtl/car_move_ctrl.sv
// Car table plus single-step move controller. A move proposes a new position, holds it for the
// collision checker and commits it if clear. Define BOUNDS_CHECK_EN to reject off-screen proposals.
module car_move_ctrl #(
    parameter int unsigned STEP      = 10,
    parameter int unsigned CHECK_LAT = 2,
    parameter int unsigned X_MAX     = 630,
    parameter int unsigned Y_MAX     = 470
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_en,
    input  logic [3:0] load_index,
    input  logic [9:0] load_x,
    input  logic [9:0] load_y,
    input  logic [1:0] load_orient,
    input  logic       move_req,
    input  logic [3:0] move_index,
    input  logic [1:0] move_dir,
    output logic       busy,
    output logic       move_done,
    output logic       move_ok,
    output logic [9:0] carX,
    output logic [9:0] carY,
    output logic [1:0] carOrient,
    output logic [3:0] carIndex,
    input  logic       collision,
    input  logic [3:0] rd_index,
    output logic [9:0] rd_x,
    output logic [9:0] rd_y,
    output logic [1:0] rd_orient,
    output logic       rd_valid
);
    localparam int unsigned CW    = 10;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned NCAR  = 16;

    if (CHECK_LAT < 1 || CHECK_LAT > 7 || X_MAX > 1023 || Y_MAX > 1023 || STEP > 1023)
    begin : g_param_err
        $error("car_move_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CW-1:0]      tab_x [NCAR];
    logic [CW-1:0]      tab_y [NCAR];
    logic [1:0]         tab_o [NCAR];
    logic [NCAR-1:0]    tab_v;

    logic [CW-1:0]      sel_x_c, sel_y_c, prop_x_c, prop_y_c;
    logic [1:0]         sel_o_c;
    logic               axis_ok_c, accept_c;
`ifdef BOUNDS_CHECK_EN
    logic               in_bounds_c;
`endif

    // Proposal and acceptance for the requested car, evaluated from the current table
    always_comb begin
        sel_x_c  = tab_x[move_index];
        sel_y_c  = tab_y[move_index];
        sel_o_c  = tab_o[move_index];
        prop_x_c = sel_x_c;
        prop_y_c = sel_y_c;
        case (move_dir)
            2'd0:    prop_y_c = sel_y_c - CW'(STEP);
            2'd1:    prop_y_c = sel_y_c + CW'(STEP);
            2'd2:    prop_x_c = sel_x_c - CW'(STEP);
            default: prop_x_c = sel_x_c + CW'(STEP);
        endcase
        // vertical cars move on dir 0/1 only, horizontal cars on dir 2/3 only
        axis_ok_c = sel_o_c[0] ? !move_dir[1] : move_dir[1];
`ifdef BOUNDS_CHECK_EN
        case (move_dir)
            2'd0:    in_bounds_c = sel_y_c >= CW'(STEP);
            2'd1:    in_bounds_c = (11'(sel_y_c) + 11'(STEP)) <= 11'(Y_MAX);
            2'd2:    in_bounds_c = sel_x_c >= CW'(STEP);
            default: in_bounds_c = (11'(sel_x_c) + 11'(STEP)) <= 11'(X_MAX);
        endcase
        accept_c = tab_v[move_index] && axis_ok_c && in_bounds_c;
`else
        accept_c = tab_v[move_index] && axis_ok_c;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            move_done <= 1'b0;
            move_ok   <= 1'b0;
            carX      <= '0;
            carY      <= '0;
            carOrient <= '0;
            carIndex  <= '0;
            rd_x      <= '0;
            rd_y      <= '0;
            rd_orient <= '0;
            rd_valid  <= 1'b0;
            tab_v     <= '0;
            for (int i = 0; i < NCAR; i++) begin
                tab_x[i] <= '0;
                tab_y[i] <= '0;
                tab_o[i] <= '0;
            end
        end else begin
            rd_x      <= tab_x[rd_index];
            rd_y      <= tab_y[rd_index];
            rd_orient <= tab_o[rd_index];
            rd_valid  <= tab_v[rd_index];
            case (state)
                IDLE: begin
                    // a load in the same cycle wins and the move is dropped
                    if (load_en) begin
                        tab_x[load_index] <= load_x;
                        tab_y[load_index] <= load_y;
                        tab_o[load_index] <= load_orient;
                        tab_v[load_index] <= 1'b1;
                    end else if (move_req) begin
                        busy <= 1'b1;
                        if (accept_c) begin
                            carX      <= prop_x_c;
                            carY      <= prop_y_c;
                            carOrient <= sel_o_c;
                            carIndex  <= move_index;
                            cnt       <= CNT_W'(1);
                            state     <= CHECK;
                        end else begin
                            move_done <= 1'b1;
                            move_ok   <= 1'b0;
                            state     <= DONE;
                        end
                    end
                end
                CHECK: begin
                    if (cnt == CNT_W'(CHECK_LAT)) begin
                        if (!collision) begin
                            tab_x[carIndex] <= carX;
                            tab_y[carIndex] <= carY;
                        end
                        move_ok   <= !collision;
                        move_done <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    busy      <= 1'b0;
                    move_done <= 1'b0;
                    move_ok   <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_car_move_ctrl.sv
// Directed plus random bench for car_move_ctrl with an array-based car table model.
module tb_car_move_ctrl;
    localparam int STEP = 10, LAT = 2, XM = 630, YM = 470;

    logic       clk = 0, rst_n = 0;
    logic       load_en = 0, move_req = 0, collision = 0;
    logic [3:0] load_index = 0, move_index = 0, rd_index = 0;
    logic [9:0] load_x = 0, load_y = 0;
    logic [1:0] load_orient = 0, move_dir = 0;
    logic       busy, move_done, move_ok, rd_valid;
    logic [9:0] carX, carY, rd_x, rd_y;
    logic [1:0] carOrient, rd_orient;
    logic [3:0] carIndex;

    car_move_ctrl #(.STEP(STEP), .CHECK_LAT(LAT), .X_MAX(XM), .Y_MAX(YM)) dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_index(load_index),
        .load_x(load_x), .load_y(load_y), .load_orient(load_orient),
        .move_req(move_req), .move_index(move_index), .move_dir(move_dir),
        .busy(busy), .move_done(move_done), .move_ok(move_ok),
        .carX(carX), .carY(carY), .carOrient(carOrient), .carIndex(carIndex),
        .collision(collision), .rd_index(rd_index), .rd_x(rd_x), .rd_y(rd_y),
        .rd_orient(rd_orient), .rd_valid(rd_valid));

    always #5 clk = ~clk;

    int n_checks = 0, n_errors = 0;
    int m_x [16], m_y [16], m_o [16], m_v [16];
    int lc_x = 0, lc_y = 0, lc_o = 0, lc_i = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_x[i] = 0; m_y[i] = 0; m_o[i] = 0; m_v[i] = 0;
        end
        lc_x = 0; lc_y = 0; lc_o = 0; lc_i = 0;
    endtask

    task automatic load(input int idx, input int x, input int y, input int o);
        load_en = 1; load_index = 4'(idx); load_x = 10'(x); load_y = 10'(y); load_orient = 2'(o);
        tick();
        load_en = 0;
        m_x[idx] = x; m_y[idx] = y; m_o[idx] = o; m_v[idx] = 1;
        check("load_no_busy", 32'(busy), 0);
    endtask

    task automatic check_rd(input int idx);
        rd_index = 4'(idx);
        tick();
        check("rd_valid", 32'(rd_valid), 32'(m_v[idx]));
        check("rd_x", 32'(rd_x), 32'(m_x[idx]));
        check("rd_y", 32'(rd_y), 32'(m_y[idx]));
        check("rd_orient", 32'(rd_orient), 32'(m_o[idx]));
    endtask

    // One request; the model decides accept/reject and predicts the timing of move_done.
    task automatic do_move(input int idx, input int dir, input int coll);
        int nx, ny;
        bit acc;
        nx = m_x[idx]; ny = m_y[idx];
        case (dir)
            0: ny = ny - STEP;
            1: ny = ny + STEP;
            2: nx = nx - STEP;
            default: nx = nx + STEP;
        endcase
        acc = (m_v[idx] != 0) && ((m_o[idx] % 2 == 1) ? (dir < 2) : (dir >= 2));
`ifdef BOUNDS_CHECK_EN
        if (nx < 0 || ny < 0 || nx > XM || ny > YM) acc = 0;
`endif
        nx = (nx + 1024) % 1024;
        ny = (ny + 1024) % 1024;
        move_req = 1; move_index = 4'(idx); move_dir = 2'(dir); collision = coll[0];
        tick();
        move_req = 0;
        check("busy_at_req", 32'(busy), 1);
        if (acc) begin
            lc_x = nx; lc_y = ny; lc_o = m_o[idx]; lc_i = idx;
            for (int k = 1; k < LAT; k++) begin
                check("done_early", 32'(move_done), 0);
                tick();
            end
            check("done_early", 32'(move_done), 0);
            check("carX", 32'(carX), 32'(lc_x));
            check("carY", 32'(carY), 32'(lc_y));
            check("carOrient", 32'(carOrient), 32'(lc_o));
            check("carIndex", 32'(carIndex), 32'(lc_i));
            tick();
            check("done_chk", 32'(move_done), 1);
            check("ok_chk", 32'(move_ok), 32'(coll == 0));
            if (coll == 0) begin
                m_x[idx] = nx; m_y[idx] = ny;
            end
        end else begin
            check("done_rej", 32'(move_done), 1);
            check("ok_rej", 32'(move_ok), 0);
            check("carX_hold", 32'(carX), 32'(lc_x));
            check("carY_hold", 32'(carY), 32'(lc_y));
        end
        collision = 0;
        tick();
        check("done_end", 32'(move_done), 0);
        check("busy_end", 32'(busy), 0);
    endtask

    initial begin
        model_clear();
        tick(); tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(move_done), 0);
        check("rst_ok", 32'(move_ok), 0);
        check("rst_carX", 32'(carX), 0);
        check("rst_carY", 32'(carY), 0);
        check("rst_carIndex", 32'(carIndex), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        rst_n = 1;
        tick();

        // vertical car moves down, clear and then blocked
        load(0, 10, 10, 1);
        do_move(0, 1, 0);
        check_rd(0);
        check("rd_y_20", 32'(rd_y), 20);
        load(0, 10, 10, 1);
        do_move(0, 1, 1);
        check_rd(0);
        check("rd_y_10", 32'(rd_y), 10);

        // horizontal car asked to move vertically
        load(1, 10, 130, 0);
        do_move(1, 0, 0);
        check_rd(1);

        // leftward underflow: rejected with bounds, wraps to 1019 without
        load(2, 5, 100, 0);
        do_move(2, 2, 0);
        check_rd(2);

        // unloaded slot
        do_move(5, 1, 0);
        check_rd(5);

        // simultaneous load and move: load wins, no move_done
        load_en = 1; load_index = 4'd3; load_x = 10'd200; load_y = 10'd300; load_orient = 2'd2;
        move_req = 1; move_index = 4'd0; move_dir = 2'd1;
        tick();
        load_en = 0; move_req = 0;
        m_x[3] = 200; m_y[3] = 300; m_o[3] = 2; m_v[3] = 1;
        check("ld_mv_done", 32'(move_done), 0);
        check("ld_mv_busy", 32'(busy), 0);
        tick();
        check("ld_mv_done2", 32'(move_done), 0);
        check_rd(3);

        // load and request while busy are ignored
        load(4, 100, 100, 0);
        move_req = 1; move_index = 4'd4; move_dir = 2'd3;
        tick();
        move_req = 0;
        lc_x = 110; lc_y = 100; lc_o = 0; lc_i = 4;
        load_en = 1; load_index = 4'd6; load_x = 10'd7; load_y = 10'd7; load_orient = 2'd1;
        move_req = 1; move_index = 4'd0;
        tick();
        load_en = 0; move_req = 0;
        tick();
        check("busy_ign_done", 32'(move_done), 1);
        check("busy_ign_ok", 32'(move_ok), 1);
        m_x[4] = 110;
        tick();
        check("busy_ign_idle", 32'(busy), 0);
        tick();
        check("busy_ign_nodone", 32'(move_done), 0);
        check_rd(6);
        check_rd(4);

        // randomized loads and moves against the model
        for (int it = 0; it < 60; it++) begin
            int op = int'($urandom_range(0, 3));
            int idx = int'($urandom_range(0, 15));
            if (op == 0) load(idx, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                              int'($urandom_range(0, 3)));
            else do_move(idx, int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
            check_rd(int'($urandom_range(0, 15)));
        end

        // reset in the middle of a checked move aborts it
        load(7, 300, 200, 1);
        move_req = 1; move_index = 4'd7; move_dir = 2'd0;
        tick();
        move_req = 0;
        check("abort_in_check", 32'(busy), 1);
        rst_n = 0;
        tick();
        rst_n = 1;
        model_clear();
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(move_done), 0);
        check("abort_carY", 32'(carY), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("abort_no_done", 32'(move_done), 0);
        end
        for (int i = 0; i < 16; i++) check_rd(i);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
